crc_engine: RTL and testbench

Parametrised, streaming CRC generator/checker; the next generation of the fixed `crc16_CCITT` byte engine. Polynomial, width, init, reflection, final XOR and datapath width are all parameters. The engine adds framing (start/end of frame), partial last beats, a valid/ready result handshake, and residue-based check mode. It sits between a byte/word stream source (UART/packet framer) and the consumer of the checksum or pass/fail flag.

---
 rtl/crc_pkg.sv | 53 +++++
 rtl/crc_word_step.sv | 39 +++
 rtl/crc_engine.sv | 107 ++++++++++
 tb/tb_crc_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and bit-level helpers for the parametrised CRC engine.
// Widths up to 32 bits are carried in 32-bit containers; the active width
// is passed explicitly so one function serves every CRC_W.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } crc_state_t;

    // Bit-reverse one byte (LSB-first input convention).
    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Bit-reverse the low n bits of v; bits at and above n come back zero.
    function automatic logic [31:0] reflect_n(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r[i] = v[n-1-i];
            end
        end
        return r;
    endfunction

    // Fold one byte MSB-first into a w-bit register with normal-form poly.
    function automatic logic [31:0] crc_byte_step(input logic [31:0] crc,
                                                  input logic [7:0]  b,
                                                  input logic [31:0] poly,
                                                  input int          w);
        logic [31:0] r;
        logic [31:0] mask;
        logic        fb;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        r    = crc & mask;
        for (int i = 7; i >= 0; i--) begin
            fb = r[w-1] ^ b[i];
            r  = (r << 1) & mask;
            if (fb) begin
                r = r ^ poly;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_word_step.sv
// Combinational fold of the first nbytes bytes of a beat into the CRC
// register. Bytes are taken from the most significant end of the beat.
module crc_word_step
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h1021,
    parameter bit               REFIN  = 1'b0,
    parameter int               DATA_W = 8,
    localparam int              NB     = DATA_W / 8,
    localparam int              KEEP_W = $clog2(NB + 1)
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [KEEP_W-1:0] nbytes,
    output logic [CRC_W-1:0]  crc_next
);

    logic [CRC_W-1:0] acc;
    logic [7:0]       byte_v;

    // Unrolled byte chain; bytes past nbytes leave the register untouched.
    always_comb begin
        // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
        acc    = crc_in;
        byte_v = '0;
        for (int i = 0; i < NB; i++) begin
            byte_v = data[DATA_W-1-8*i -: 8];
            if (REFIN) begin
                byte_v = reflect8(byte_v);
            end
            if (i < int'(nbytes)) begin
                acc = CRC_W'(crc_byte_step(32'(acc), byte_v, 32'(POLY), CRC_W));
            end
        end
        crc_next = acc;
    end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC generator/checker with sof/eof framing, partial last beat,
// and a valid/ready result handshake. Results are fully registered.
module crc_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h1021,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter bit               REFIN   = 1'b0,
    parameter bit               REFOUT  = 1'b0,
    parameter logic [CRC_W-1:0] XOROUT  = 16'h0000,
    parameter logic [CRC_W-1:0] RESIDUE = 16'h0000,
    parameter int               DATA_W  = 8,
    localparam int              NB      = DATA_W / 8,
    localparam int              KEEP_W  = $clog2(NB + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sync_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_ok,
    output logic              out_valid,
    input  logic              out_ready
);

    crc_state_t        state;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  step_base;
    logic [CRC_W-1:0]  step_next;
    logic [CRC_W-1:0]  final_val;
    logic [KEEP_W-1:0] step_bytes;
    logic              accept;
    logic              take_beat;

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);

    // Beat qualification, byte count and the post-processed output value.
    always_comb begin
        accept     = in_valid && in_ready;
        // A sof beat always restarts from INIT, which also covers mid-frame abort.
        take_beat  = accept && (in_sof || state == BUSY);
        step_base  = in_sof ? INIT : crc_q;
        step_bytes = KEEP_W'(NB);
        if (in_eof && in_keep != '0) begin
            step_bytes = in_keep;
        end
        final_val = REFOUT ? CRC_W'(reflect_n(32'(step_next), CRC_W)) : step_next;
        final_val = final_val ^ XOROUT;
    end

    crc_word_step #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .REFIN  (REFIN),
        .DATA_W (DATA_W)
    ) u_word_step (
        .crc_in   (step_base),
        .data     (data_in),
        .nbytes   (step_bytes),
        .crc_next (step_next)
    );

    // FSM, running CRC register and held result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            state   <= IDLE;
            crc_q   <= INIT;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else if (sync_reset) begin
            state   <= IDLE;
            crc_q   <= INIT;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else begin
            case (state)
                IDLE, BUSY: begin
                    if (take_beat) begin
                        crc_q <= step_next;
                        if (in_eof) begin
                            state   <= DONE;
                            crc_out <= final_val;
                            crc_ok  <= (step_next == RESIDUE);
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench: three engine instances (CRC-16 byte, CRC-16 32-bit word,
// CRC-32 byte) sharing clock, resets and out_ready.
module tb_crc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n    = 1'b0;
    logic sync_reset = 1'b0;
    logic out_ready  = 1'b0;

    // Byte bus shared by instances a (CRC-16) and c (CRC-32).
    logic       v8 = 1'b0, sof8 = 1'b0, eof8 = 1'b0;
    logic [0:0] keep8 = 1'b0;
    logic [7:0] d8 = 8'h00;

    // Word bus for instance b.
    logic        v32 = 1'b0, sof32 = 1'b0, eof32 = 1'b0;
    logic [2:0]  keep32 = 3'd0;
    logic [31:0] d32 = 32'h0;

    logic        a_rdy, a_ok, a_vld;
    logic [15:0] a_crc;
    logic        b_rdy, b_ok, b_vld;
    logic [15:0] b_crc;
    logic        c_rdy, c_ok, c_vld;
    logic [31:0] c_crc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    crc_engine u_a (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .in_valid(v8), .in_ready(a_rdy), .in_sof(sof8), .in_eof(eof8),
        .in_keep(keep8), .data_in(d8), .crc_out(a_crc), .crc_ok(a_ok),
        .out_valid(a_vld), .out_ready(out_ready)
    );

    crc_engine #(.DATA_W(32)) u_b (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .in_valid(v32), .in_ready(b_rdy), .in_sof(sof32), .in_eof(eof32),
        .in_keep(keep32), .data_in(d32), .crc_out(b_crc), .crc_ok(b_ok),
        .out_valid(b_vld), .out_ready(out_ready)
    );

    crc_engine #(
        .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
        .REFIN(1'b1), .REFOUT(1'b1), .XOROUT(32'hFFFFFFFF), .RESIDUE(32'h0),
        .DATA_W(8)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .in_valid(v8), .in_ready(c_rdy), .in_sof(sof8), .in_eof(eof8),
        .in_keep(keep8), .data_in(d8), .crc_out(c_crc), .crc_ok(c_ok),
        .out_valid(c_vld), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d, input logic sof, input logic eof);
        @(negedge clk);
        v8 = 1'b1; d8 = d; sof8 = sof; eof8 = eof; keep8 = 1'b0;
    endtask

    task automatic end8();
        @(negedge clk);
        v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic sof, input logic eof, input logic [2:0] keep);
        @(negedge clk);
        v32 = 1'b1; d32 = d; sof32 = sof; eof32 = eof; keep32 = keep;
    endtask

    task automatic end32();
        @(negedge clk);
        v32 = 1'b0; sof32 = 1'b0; eof32 = 1'b0;
    endtask

    task automatic frame_msg8(input int corrupt_idx);
        for (int i = 0; i < 9; i++) begin
            send8((i == corrupt_idx) ? 8'h36 : msg[i], i == 0, i == 8);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_crc_out", 32'(a_crc), 32'h0);
        check("rst_crc_ok", 32'(a_ok), 32'h0);
        check("rst_out_valid", 32'(a_vld), 32'h0);
        check("rst_in_ready", 32'(a_rdy), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;

        // "123456789" on the byte bus, result stalled for 5 cycles.
        frame_msg8(-1);
        end8();
        check("ccitt_valid", 32'(a_vld), 32'h1);
        check("ccitt_crc", 32'(a_crc), 32'h29B1);
        check("crc32_crc", c_crc, 32'hCBF43926);
        check("done_in_ready", 32'(a_rdy), 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 32'(a_vld), 32'h1);
            check("stall_crc", 32'(a_crc), 32'h29B1);
            check("stall_in_ready", 32'(a_rdy), 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("post_hs_in_ready", 32'(a_rdy), 32'h1);
        check("post_hs_valid", 32'(a_vld), 32'h0);

        // Check mode: message plus its CRC leaves a zero register.
        v8 = 1'b1; d8 = msg[0]; sof8 = 1'b1; eof8 = 1'b0;
        for (int i = 1; i < 9; i++) send8(msg[i], 1'b0, 1'b0);
        send8(8'h29, 1'b0, 1'b0);
        send8(8'hB1, 1'b0, 1'b1);
        end8();
        check("residue_ok", 32'(a_ok), 32'h1);
        check("residue_crc", 32'(a_crc), 32'h0);

        // Corrupted data byte.
        frame_msg8(4);
        eof8 = 1'b0;
        send8(8'h29, 1'b0, 1'b0);
        send8(8'hB1, 1'b0, 1'b1);
        end8();
        check("corrupt_data_ok", 32'(a_ok), 32'h0);

        // Corrupted CRC byte.
        frame_msg8(-1);
        eof8 = 1'b0;
        send8(8'h29, 1'b0, 1'b0);
        send8(8'hB0, 1'b0, 1'b1);
        end8();
        check("corrupt_crc_ok", 32'(a_ok), 32'h0);

        // Abort: partial frame, then a full frame with a fresh sof.
        send8(8'h31, 1'b1, 1'b0);
        send8(8'h32, 1'b0, 1'b0);
        end8();
        check("abort_no_result", 32'(a_vld), 32'h0);
        frame_msg8(-1);
        end8();
        check("abort_valid", 32'(a_vld), 32'h1);
        check("abort_crc", 32'(a_crc), 32'h29B1);
        @(negedge clk);
        check("abort_single_result", 32'(a_vld), 32'h0);

        // Synchronous reset on the eof beat discards the frame.
        send8(8'h31, 1'b1, 1'b0);
        send8(8'h32, 1'b0, 1'b0);
        @(negedge clk);
        v8 = 1'b1; d8 = 8'h33; sof8 = 1'b0; eof8 = 1'b1; sync_reset = 1'b1;
        end8();
        sync_reset = 1'b0;
        check("srst_valid", 32'(a_vld), 32'h0);
        check("srst_crc", 32'(a_crc), 32'h0);
        check("srst_in_ready", 32'(a_rdy), 32'h1);

        // Beat without sof in IDLE is discarded; a proper frame follows.
        send8(8'h39, 1'b0, 1'b1);
        end8();
        check("discard_valid", 32'(a_vld), 32'h0);
        frame_msg8(-1);
        end8();
        check("after_discard_crc", 32'(a_crc), 32'h29B1);

        // Asynchronous reset mid-frame.
        send8(8'h31, 1'b1, 1'b0);
        send8(8'h32, 1'b0, 1'b0);
        @(negedge clk);
        v8 = 1'b0; sof8 = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_crc", 32'(a_crc), 32'h0);
        check("arst_ok", 32'(a_ok), 32'h0);
        check("arst_valid", 32'(a_vld), 32'h0);
        check("arst_crc32", c_crc, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send8(8'h39, 1'b0, 1'b1);
        end8();
        check("arst_no_result", 32'(a_vld), 32'h0);

        // 32-bit datapath: partial last beat, junk in dropped bytes.
        send32(32'h31323334, 1'b1, 1'b0, 3'd0);
        send32(32'h35363738, 1'b0, 1'b0, 3'd0);
        send32(32'h39AABBCC, 1'b0, 1'b1, 3'd1);
        end32();
        check("w32_valid", 32'(b_vld), 32'h1);
        check("w32_crc", 32'(b_crc), 32'h29B1);

        // keep=0 means all four bytes: trailing 0x00 keeps the zero residue.
        send32(32'h31323334, 1'b1, 1'b0, 3'd0);
        send32(32'h35363738, 1'b0, 1'b0, 3'd0);
        send32(32'h3929B100, 1'b0, 1'b1, 3'd0);
        end32();
        check("w32_keep0_ok", 32'(b_ok), 32'h1);
        check("w32_keep0_crc", 32'(b_crc), 32'h0);

        // keep=3 drops the trailing 0xFF.
        send32(32'h31323334, 1'b1, 1'b0, 3'd0);
        send32(32'h35363738, 1'b0, 1'b0, 3'd0);
        send32(32'h3929B1FF, 1'b0, 1'b1, 3'd3);
        end32();
        check("w32_keep3_ok", 32'(b_ok), 32'h1);

        // keep=0 with 0xFF folds it in and breaks the residue.
        send32(32'h31323334, 1'b1, 1'b0, 3'd0);
        send32(32'h35363738, 1'b0, 1'b0, 3'd0);
        send32(32'h3929B1FF, 1'b0, 1'b1, 3'd0);
        end32();
        check("w32_keep0_bad_ok", 32'(b_ok), 32'h0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
